// File: rtl/dotmatrix_pkg.sv
// Shared types, pin map and row-select decode for the dot-matrix link capture model.
// Included by dm_strobe_sync and dotmatrix_capture.
package dotmatrix_pkg;

    localparam int DM_ROWS = 16;
    localparam int DM_COLS = 16;

    typedef logic [DM_COLS-1:0] dm_row_t;
    typedef logic [3:0]         dm_idx_t;

    // Link pins in bus order. The strobes deliver rising-edge events and the
    // data lines deliver their sampled level.
    typedef struct packed {
        logic le;
        logic csdi;
        logic cclk;
        logic rsdi;
        logic rclk;
    } dm_pins_t;

    localparam dm_pins_t DM_EDGE_PINS = '{le: 1'b1, csdi: 1'b0, cclk: 1'b1, rsdi: 1'b0, rclk: 1'b1};

    typedef struct packed {
        logic    valid;
        dm_idx_t idx;
    } dm_rowsel_t;

    // Position of the single zero bit; valid only when exactly one bit is zero.
    function automatic dm_rowsel_t onehot0_index(input dm_row_t vec);
        dm_rowsel_t sel;
        int         zeros;
        sel   = '0;
        zeros = 0;
        for (int i = 0; i < DM_ROWS; i++) begin
            if (!vec[i]) begin
                zeros++;
                sel.idx = dm_idx_t'(i);
            end
        end
        sel.valid = (zeros == 1);
        return sel;
    endfunction

endpackage

// File: rtl/dm_strobe_sync.sv
// Input conditioning for the link pins: optional synchroniser chain, sample stage q1,
// history stage q2. Strobe lanes output q1 & ~q2, data lanes output q1.
module dm_strobe_sync #(
    parameter int               WIDTH       = 5,
    parameter int               SYNC_STAGES = 0,
    parameter logic [WIDTH-1:0] EDGE_MASK   = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] evt
);

    logic [WIDTH-1:0] staged;
    logic [WIDTH-1:0] q1_q, q1_d;
    logic [WIDTH-1:0] q2_q, q2_d;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [WIDTH-1:0] sync_q [SYNC_STAGES];
            logic [WIDTH-1:0] sync_d [SYNC_STAGES];

            always_comb begin
                sync_d[0] = din;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_d[i];
                    end
                end
            end

            assign staged = sync_q[SYNC_STAGES-1];
        end else begin : g_nosync
            assign staged = din;
        end
    endgenerate

    always_comb begin
        q1_d = staged;
        q2_d = q1_q;
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q1_q <= '0;
            q2_q <= '0;
        end else begin
            q1_q <= q1_d;
            q2_q <= q2_d;
        end
    end

    // Data lanes come from the same q1 stage as the strobes, keeping them aligned.
    assign evt = (EDGE_MASK & q1_q & ~q2_q) | (~EDGE_MASK & q1_q);

endmodule

// File: rtl/dotmatrix_capture.sv
// Receiving end of the 16x16 dot-matrix serial link: rebuilds the displayed image.
// Optional macro DOTMATRIX_ROWSWAP_EN: write index becomes active_row ^ 1.
module dotmatrix_capture
    import dotmatrix_pkg::*;
#(
    parameter int SYNC_STAGES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rclk,
    input  logic        rsdi,
    input  logic        cclk,
    input  logic        csdi,
    input  logic        le,
    input  logic        oeb,
    input  logic [3:0]  rd_row,
    output logic [15:0] rd_data,
    output logic        frame_done,
    output logic        row_err
);

    dm_pins_t   pins_raw;
    dm_pins_t   pins_evt;
    dm_rowsel_t row_sel;
    dm_idx_t    wr_idx;

    dm_row_t col_sr_q, col_sr_d;
    dm_row_t row_sr_q, row_sr_d;
    dm_row_t fb_q [DM_ROWS];
    dm_row_t fb_d [DM_ROWS];
    logic    row_err_q, row_err_d;
    logic    frame_done_q, frame_done_d;

    assign pins_raw = {le, csdi, cclk, rsdi, rclk};

    dm_strobe_sync #(
        .WIDTH      ($bits(dm_pins_t)),
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE_MASK  (DM_EDGE_PINS)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .din  (pins_raw),
        .evt  (pins_evt)
    );

    assign row_sel = onehot0_index(row_sr_q);

`ifdef DOTMATRIX_ROWSWAP_EN
    assign wr_idx = row_sel.idx ^ 4'd1;
`else
    assign wr_idx = row_sel.idx;
`endif

    // The latch reads col_sr_q/row_sr_q, so a shift in the same cycle lands after it.
    always_comb begin
        col_sr_d     = col_sr_q;
        row_sr_d     = row_sr_q;
        fb_d         = fb_q;
        row_err_d    = row_err_q;
        frame_done_d = 1'b0;

        if (pins_evt.cclk) begin
            col_sr_d = {col_sr_q[DM_COLS-2:0], pins_evt.csdi};
        end
        if (pins_evt.rclk) begin
            row_sr_d = {row_sr_q[DM_ROWS-2:0], pins_evt.rsdi};
        end
        if (pins_evt.le) begin
            if (row_sel.valid) begin
                fb_d[wr_idx] = oeb ? '0 : col_sr_q;
                frame_done_d = (row_sel.idx == 4'd15);
            end else begin
                row_err_d = 1'b1;
            end
        end
    end

    // NOTE: the framebuffer is built from flops with an asynchronous reset so that
    // reset blanks every row at once; a RAM-based store could not be cleared this way.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_sr_q     <= '0;
            row_sr_q     <= '1;
            row_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
            for (int r = 0; r < DM_ROWS; r++) begin
                fb_q[r] <= '0;
            end
        end else begin
            col_sr_q     <= col_sr_d;
            row_sr_q     <= row_sr_d;
            row_err_q    <= row_err_d;
            frame_done_q <= frame_done_d;
            for (int r = 0; r < DM_ROWS; r++) begin
                fb_q[r] <= fb_d[r];
            end
        end
    end

    assign rd_data    = fb_q[rd_row];
    assign frame_done = frame_done_q;
    assign row_err    = row_err_q;

endmodule

// File: doc/dotmatrix_capture.md
Name: dotmatrix_capture

Overview:
- Receiving end of the 16x16 dot-matrix serial link: decodes the row chain (rclk/rsdi) and the column chain (cclk/csdi/le) exactly as the physical shift-register board does.
- Reconstructs the displayed image into a 16x16 framebuffer with a random-access read port.
- Sits beside the screen driver in simulation/FPGA builds as a display model, and feeds frame mirroring (VGA/UART dump) and self-check logic.

Parameters:
- SYNC_STAGES, 0, extra input flops ahead of the edge-detect stage (0 for same-domain use, 2 for an external link).

Ports:
- clk  input  1  system clock (12 MHz)
- reset  input  1  asynchronous, active-high reset
- rclk  input  1  row shift clock
- rsdi  input  1  row serial data, active-low row select
- cclk  input  1  column shift clock
- csdi  input  1  column serial data, 1 = LED on
- le  input  1  column latch enable
- oeb  input  1  output enable, active-low
- rd_row  input  4  framebuffer read row
- rd_data  output  16  framebuffer row rd_row; bit 15 = column 0
- frame_done  output  1  one-cycle pulse when row 15 is latched
- row_err  output  1  sticky: le latched while the row chain did not hold exactly one zero

Behaviour:
- One clock, `clk`. Asynchronous active-high `reset`.
- Input path:
  - rclk, rsdi, cclk, csdi, le pass through SYNC_STAGES flops, then one sample stage q1 and one history stage q2.
  - Rising edge of a strobe = q1 & ~q2.
  - Data bits are taken from the same q1 stage, so csdi/rsdi are sampled aligned with their clock.
- Column chain, on cclk edge: col_sr <= {col_sr[14:0], csdi_q1}.
  - After exactly 16 edges, the first bit shifted (column 0) sits at bit 15.
  - More than 16 edges: only the last 16 bits are kept, no error.
- Row chain, on rclk edge: row_sr <= {row_sr[14:0], rsdi_q1}.
  - Active row = index of the single 0 bit in row_sr. Valid only if exactly one bit is 0.
- On le edge:
  - If the row is valid, fb[active_row] <= col_sr.
  - Otherwise fb is unchanged and row_err <= 1.
  - Simultaneous le and cclk edges: the latch takes the pre-shift col_sr.
  - Simultaneous le and rclk edges: the latch uses the pre-shift row_sr.
- frame_done = 1 for one cycle, in the cycle fb[15] is written.
- oeb:
  - oeb = 1 at an le edge suppresses the write; the row stays blank and is written as 0.
  - oeb does not affect the shift registers.
- Read port:
  - rd_data = fb[rd_row], combinational.
  - Write-to-read latency with SYNC_STAGES=0: 2 clk from le rising at the pin to new data on rd_data.
- Reset (asynchronous, any time, including mid-line):
  - col_sr = 0
  - row_sr = 16'hFFFF (no valid row)
  - all fb rows = 0
  - q1/q2 = 0
  - frame_done = 0, row_err = 0
  - A partially shifted line is discarded.
- row_err clears only on reset.

Optional Feature:
- Macro DOTMATRIX_ROWSWAP_EN.
- When defined: the write index is active_row ^ 4'd1, undoing the v01 board row-pair swap so fb matches logical game coordinates.
- When undefined: fb is indexed by physical row.
- frame_done always follows the write to physical row 15.

Decomposition:
- Package dotmatrix_pkg:
  - DM_ROWS=16, DM_COLS=16
  - typedef dm_row_t (logic [15:0])
  - typedef dm_idx_t (logic [3:0])
  - function onehot0_index (zero-position decode plus valid flag)
- One natural sub-module: dm_strobe_sync. It holds the SYNC_STAGES chain plus q1/q2, and is instantiated once for the 5-bit input bus.

Test Plan:
- Full-frame stimulus:
  - Stimulus: driver-equivalent frame with ball x=3, y=5, lpaddle=16'h0070, rpaddle=16'h0E00.
  - Response: rd_data for row 5 has bit (15-(15-3)) set plus paddle bits per row, and frame_done pulses once after row 15.
- Row-0 line:
  - Stimulus: rsdi=0 on the first rclk, csdi pattern 16'hA5A5 (column 0 first), then le.
  - Response: fb[0]=16'hA5A5 two clocks after le.
- Missing row select:
  - Stimulus: le with row_sr=16'hFFFF, i.e. no row-select zero shifted.
  - Response: fb unchanged, row_err=1 and it stays set.
- Over-long column burst:
  - Stimulus: 20 cclk pulses, data 1,1,1,1 then 16'h00FF, then le on row 3.
  - Response: fb[3]=16'h00FF.
- Mid-line reset:
  - Stimulus: assert reset after 8 cclk pulses, then release and send a full line for row 2 = 16'h8001.
  - Response: all other rows 0, fb[2]=16'h8001, row_err=0.
- Row swap:
  - Stimulus: with DOTMATRIX_ROWSWAP_EN defined, write physical row 4 = 16'h1234.
  - Response: rd_row=5 returns 16'h1234, and rd_row=4 returns 0.
